text_video_generator: RTL and testbench



---
 rtl/text_video_generator.sv | 138 +++++++++++++
 tb/tb_text_video_generator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_video_generator.sv
// Text-mode pixel pipeline: fetches character codes and glyph rows for an
// 80x25 screen of 16x32 px cells, with inverse video and a blinking cursor.
module text_video_generator #(
  parameter int unsigned HBP          = 248,
  parameter int unsigned VBP          = 150,
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 25,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic        hblank,
  input  logic        vblank,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  input  logic        cursor_en,
  output logic [10:0] buffer_addr,
  input  logic [7:0]  buffer_data,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        video,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Per-pixel sideband carried alongside the two memory reads.
  typedef struct packed {
    logic [2:0] px;
    logic       blank;
    logic       hsync;
    logic       vsync;
    logic       cursor_hit;
  } side_t;

  logic [10:0] x, y;
  logic [6:0]  col;
  logic [5:0]  row;
  logic [10:0] row_ext;
  logic [10:0] addr_d;
  logic [3:0]  line_d;
  side_t       side_d;
  logic [2:0]  bit_sel;
  logic        video_d;
  logic        vsync_rise;
  logic        unused_lsbs;

  side_t [3:0]      side_q;
  logic [3:0]       line_s1_q, line_s2_q;
  logic             inv_s1_q, inv_s2_q;
  logic [10:0]      buffer_addr_q, rom_addr_q;
  logic             video_q, hsync_out_q, vsync_out_q;
  logic             vsync_prev_q;
  logic [CNT_W-1:0] blink_cnt_q;
  logic             blink_phase_q;

  assign x           = hc - 11'(HBP);
  assign y           = vc - 11'(VBP);
  assign col         = x[10:4];
  assign row         = y[10:5];
  assign line_d      = y[4:1];
  assign unused_lsbs = x[0] ^ y[0];

  // row*80 + col as (row*64) + (row*16) + col; max 1999 fits in 11 bits.
  assign row_ext = {5'd0, row};
  assign addr_d  = (row_ext << 6) + (row_ext << 4) + {4'd0, col};

  assign side_d.px         = x[3:1];
  assign side_d.blank      = hblank | vblank;
  assign side_d.hsync      = hsync;
  assign side_d.vsync      = vsync;
  assign side_d.cursor_hit = cursor_en & (col == cursor_x) & (row == {1'b0, cursor_y})
                             & (cursor_x < 7'(COLS)) & (cursor_y < 5'(ROWS));

  // Glyph rows are stored MSB-first: bit 7 is the leftmost font pixel.
  assign bit_sel    = 3'd7 - side_q[3].px;
  assign video_d    = ~side_q[3].blank
                      & (rom_data[bit_sel] ^ inv_s2_q ^ (side_q[3].cursor_hit & blink_phase_q));
  assign vsync_rise = vsync & ~vsync_prev_q;

  // NOTE: every register here uses <= so all stages sample the values from
  // before the edge; blocking assignments would collapse the pipeline.
  always_ff @(posedge clk) begin
    if (clr) begin
      side_q        <= '0;
      line_s1_q     <= '0;
      line_s2_q     <= '0;
      inv_s1_q      <= 1'b0;
      inv_s2_q      <= 1'b0;
      buffer_addr_q <= '0;
      rom_addr_q    <= '0;
      video_q       <= 1'b0;
      hsync_out_q   <= 1'b0;
      vsync_out_q   <= 1'b0;
      vsync_prev_q  <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      // E0: character address and sideband capture.
      buffer_addr_q <= side_d.blank ? 11'd0 : addr_d;
      side_q        <= {side_q[2:0], side_d};
      line_s1_q     <= line_d;
      line_s2_q     <= line_s1_q;

      // E2: buffer data is valid; form the glyph-row address.
      rom_addr_q <= {buffer_data[6:0], line_s2_q};
      inv_s1_q   <= buffer_data[7];
      inv_s2_q   <= inv_s1_q;

      // E4: ROM data is valid; final pixel and aligned syncs.
      video_q     <= video_d;
      hsync_out_q <= side_q[3].hsync;
      vsync_out_q <= side_q[3].vsync;

      vsync_prev_q <= vsync;
      if (vsync_rise) begin
        if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  assign buffer_addr = buffer_addr_q;
  assign rom_addr    = rom_addr_q;
  assign video       = video_q;
  assign hsync_out   = hsync_out_q;
  assign vsync_out   = vsync_out_q;

endmodule

// File: tb/tb_text_video_generator.sv
// Bench for text_video_generator: synchronous-read buffer/ROM models, a
// per-cycle behavioural reference, and directed literal checks.
module tb_text_video_generator;

  localparam int HBP = 248;
  localparam int VBP = 150;
  localparam int NE  = 8192;

  logic        clk = 1'b0;
  logic        clr;
  logic [10:0] hc, vc;
  logic        hblank, vblank, hsync, vsync;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        cursor_en;
  logic [10:0] buffer_addr, rom_addr;
  logic [7:0]  buffer_data, rom_data;
  logic        video, hsync_out, vsync_out;

  logic [7:0] buf_mem [0:2047];
  logic [7:0] rom_mem [0:2047];

  int n_vec  = 0;
  int n_miss = 0;

  text_video_generator dut (
    .clk(clk), .clr(clr), .hc(hc), .vc(vc),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .buffer_addr(buffer_addr), .buffer_data(buffer_data),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .video(video), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    buffer_data <= buf_mem[buffer_addr];
    rom_data    <= rom_mem[rom_addr];
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        clr;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        blank;
    logic        hs;
    logic        vs;
    logic [6:0]  cx;
    logic [4:0]  cy;
    logic        cen;
  } rec_t;

  rec_t hist [NE];
  bit   phase_at [NE];
  int   n_edges = 0;
  int   rises   = 0;
  bit   prev_vs = 1'b0;

  // Everything the DUT sees at an edge, plus the cursor phase in force then.
  always @(posedge clk) begin
    if (n_edges < NE) begin
      hist[n_edges].clr   = clr;
      hist[n_edges].hc    = hc;
      hist[n_edges].vc    = vc;
      hist[n_edges].blank = hblank | vblank;
      hist[n_edges].hs    = hsync;
      hist[n_edges].vs    = vsync;
      hist[n_edges].cx    = cursor_x;
      hist[n_edges].cy    = cursor_y;
      hist[n_edges].cen   = cursor_en;
      phase_at[n_edges]   = ((rises / 30) % 2) == 0;
      if (clr) begin
        rises   = 0;
        prev_vs = 1'b0;
      end else begin
        if (vsync && !prev_vs) rises++;
        prev_vs = vsync;
      end
      n_edges++;
    end
  end

  function automatic int m_x(rec_t r);
    return (int'(r.hc) - HBP + 2048) % 2048;
  endfunction

  function automatic int m_y(rec_t r);
    return (int'(r.vc) - VBP + 2048) % 2048;
  endfunction

  function automatic int m_addr(rec_t r);
    if (r.blank) return 0;
    return ((m_y(r) / 32) * 80 + m_x(r) / 16) % 2048;
  endfunction

  function automatic int m_rom_addr(rec_t r);
    logic [7:0] ch;
    ch = buf_mem[m_addr(r)];
    return (int'(ch) % 128) * 16 + (m_y(r) % 32) / 2;
  endfunction

  function automatic int m_video(rec_t r, bit ph);
    logic [7:0] ch, glyph;
    int col, row, px;
    bit hit;
    if (r.blank) return 0;
    col   = m_x(r) / 16;
    row   = m_y(r) / 32;
    px    = (m_x(r) % 16) / 2;
    ch    = buf_mem[m_addr(r)];
    glyph = rom_mem[m_rom_addr(r)];
    hit   = r.cen && (col == int'(r.cx)) && (row == int'(r.cy));
    return int'(glyph[7-px] ^ ch[7] ^ (hit & ph));
  endfunction

  function automatic bit clean(int a, int b);
    for (int k = a; k <= b; k++) if (hist[k].clr) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d at t=%0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int   m;
    rec_t r, s;
    if (n_edges > 0 && n_edges <= NE) begin
      m = n_edges - 1;
      r = hist[m];
      if (r.clr) begin
        check("rst_video", int'(video), 0);
        check("rst_hsync_out", int'(hsync_out), 0);
        check("rst_vsync_out", int'(vsync_out), 0);
        check("rst_buffer_addr", int'(buffer_addr), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
      end else begin
        check("buffer_addr", int'(buffer_addr), m_addr(r));
        if (m >= 2 && clean(m - 2, m) && !hist[m-2].blank)
          check("rom_addr", int'(rom_addr), m_rom_addr(hist[m-2]));
        if (m >= 4 && clean(m - 4, m)) begin
          s = hist[m-4];
          check("video", int'(video), m_video(s, phase_at[m]));
          check("hsync_out", int'(hsync_out), int'(s.hs));
          check("vsync_out", int'(vsync_out), int'(s.vs));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int h, input int v, input bit hb, input bit vb,
                       input bit hs, input bit vs);
    hc     = 11'(h);
    vc     = 11'(v);
    hblank = hb;
    vblank = vb;
    hsync  = hs;
    vsync  = vs;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic sync_sweep(input bit is_v, input int start, input int width,
                            input int len);
    int first_out, cnt, h;
    bit p;
    first_out = -1;
    cnt       = 0;
    for (int i = 0; i < len; i++) begin
      tick();
      if (is_v ? vsync_out : hsync_out) begin
        cnt++;
        if (first_out < 0) first_out = i;
      end
      h = (1560 + i) % 1688;
      p = (i >= start) && (i < start + width);
      drive(h, 900, 1'b1, 1'b1, is_v ? 1'b0 : p, is_v ? p : 1'b0);
    end
    check(is_v ? "vsync_delay" : "hsync_delay", first_out - start - 1, 4);
    check(is_v ? "vsync_width" : "hsync_width", cnt, width);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int h, v;
    bit hb, vb;

    for (int i = 0; i < 2048; i++) begin
      buf_mem[i] = 8'($urandom);
      rom_mem[i] = 8'($urandom);
    end
    clr = 1'b1; cursor_x = '0; cursor_y = '0; cursor_en = 1'b0;
    drive(700, 500, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("init_rst_video", int'(video), 0);
      check("init_rst_hsync_out", int'(hsync_out), 0);
      check("init_rst_buffer_addr", int'(buffer_addr), 0);
    end
    clr = 1'b0;
    idle(6);

    // Address corners and a mid-screen cell.
    tick(); drive(HBP + 79*16, VBP + 24*32, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); check("addr_max", int'(buffer_addr), 1999);
    drive(HBP, VBP, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); check("addr_zero", int'(buffer_addr), 0);
    drive(HBP + 5*16 + 3, VBP + 3*32 + 7, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); check("addr_mid", int'(buffer_addr), 245);
    drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(6);

    // Glyph fetch: 'A' on glyph line 1, only leftmost font pixel set.
    buf_mem[0]    = 8'h41;
    rom_mem[1041] = 8'h80;
    for (int i = 0; i < 21; i++) begin
      tick();
      if (i == 3) check("rom_addr_glyph", int'(rom_addr), 1041);
      if (i >= 5) check("glyph_px", int'(video), ((i - 5) < 2) ? 1 : 0);
      if (i < 16) drive(HBP + i, VBP + 2, 1'b0, 1'b0, 1'b0, 1'b0);
      else        drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    idle(6);

    // Inverse video lights the whole cell; hblank overrides it.
    buf_mem[0]    = 8'hC1;
    rom_mem[1041] = 8'h00;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i >= 5) check("inverse_cell", int'(video), ((i - 5) < 16) ? 1 : 0);
      if (i < 16)      drive(HBP + i, VBP + 2, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (i < 20) drive(HBP, VBP + 2, 1'b1, 1'b0, 1'b0, 1'b0);
      else             drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Cursor blink: restart the frame counter, then count vsync rises.
    tick(); clr = 1'b1; drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); tick(); clr = 1'b0;
    idle(6);
    buf_mem[0] = 8'h20;
    for (int l = 0; l < 16; l++) rom_mem[512 + l] = 8'h00;
    cursor_en = 1'b1; cursor_x = 7'd0; cursor_y = 5'd0;
    for (int f = 0; f < 65; f++) begin
      tick(); drive(HBP, VBP, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (5) tick();
      check("blink", int'(video), ((f / 30) % 2 == 0) ? 1 : 0);
      tick(); drive(HBP, VBP, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    // Inverse character under a shown cursor cancels to dark.
    idle(6);
    buf_mem[0] = 8'hA0;
    tick(); drive(HBP + 4, VBP + 9, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    check("inv_cursor_cancel", int'(video), 0);
    cursor_en = 1'b0;
    idle(6);

    // Sync pass-through alignment.
    sync_sweep(1'b0, 16, 112, 140);
    idle(6);
    sync_sweep(1'b1, 4, 7, 30);
    idle(6);

    // Randomised traffic with a mid-line reset.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (i >= 1001 && i <= 1003) check("mid_rst_video", int'(video), 0);
      clr = (i >= 1000 && i < 1003);
      if ($urandom_range(7) == 0) begin
        h  = $urandom_range(1687);
        v  = $urandom_range(1065);
        hb = $urandom_range(1) == 1;
        vb = !hb;
      end else begin
        h  = HBP + $urandom_range(1279);
        v  = VBP + $urandom_range(799);
        hb = 1'b0;
        vb = 1'b0;
      end
      if ($urandom_range(3) == 0 && !hb && !vb) begin
        cursor_x = 7'((h - HBP) / 16);
        cursor_y = 5'((v - VBP) / 32);
      end else begin
        cursor_x = 7'($urandom_range(127));
        cursor_y = 5'($urandom_range(31));
      end
      cursor_en = $urandom_range(3) != 0;
      drive(h, v, hb, vb, $urandom_range(7) == 0, $urandom_range(1) == 1);
    end
    clr = 1'b0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
